// File: rtl/rr_grant_encoder8.sv
// 8-requester round-robin arbiter with a registered 3-bit grant index and a
// mandatory one-cycle idle gap between grants. Define ARB_TIMEOUT_EN to enable
// the hold counter and forced release with a timeout pulse.
module rr_grant_encoder8 #(
  parameter  int MAX_HOLD = 16,
  localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] idx_nxt;
  logic       valid_nxt, busy_nxt, timeout_nxt;
  logic [2:0] sel_idx, cand;
  logic       sel_found;
  logic       hold_expired;
  logic       release_now;

  // Search starts just past the last winner, so that winner ranks lowest.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    cand      = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = ptr + 3'(k);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign hold_expired = (cnt == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE) begin
      cnt_nxt = '0;
    end else if (!hold_expired) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  logic unused_hold_cfg;

  assign hold_expired    = 1'b0;
  assign unused_hold_cfg = ^(MAX_HOLD + CNT_W);
`endif

  assign release_now = done || !req[grant_idx] || hold_expired;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = grant_idx;
    valid_nxt   = grant_valid;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt = GRANT;
          idx_nxt   = sel_idx;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt   = IDLE;
          ptr_nxt     = grant_idx;
          valid_nxt   = 1'b0;
          busy_nxt    = 1'b0;
          // done wins a same-cycle collision with the hold limit.
          timeout_nxt = hold_expired && !done;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= 3'd7;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant_idx   <= idx_nxt;
      grant_valid <= valid_nxt;
      busy        <= busy_nxt;
      timeout     <= timeout_nxt;
    end
  end

endmodule
